// File: rtl/spi_cmd_seq.sv
// SPI command sequencer: buffers tagged command words in a FIFO and frames them into
// SPI transactions with slave-select lead/trail timing, byte hand-off and SCK enable pulses.
module spi_cmd_seq #(
  parameter int DW           = 8,
  parameter int AW           = 4,
  parameter int CLK_DIV      = 12,
  parameter int STARTUP_CYC  = 1500,
  parameter int SS_LEAD_CYC  = 500,
  parameter int SS_TRAIL_CYC = 500
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_wr,
  input  logic [DW:0]   cmd_data,
  output logic          cmd_full,
  output logic [AW:0]   cmd_count,
  output logic          cmd_ovf,
  input  logic          busy_spi,
  output logic          spi_ss_n,
  output logic          spi_send,
  output logic [DW-1:0] data_spi,
  output logic          ena_2clk,
  output logic          spi_end_tx,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    ST_STARTUP, ST_IDLE, ST_LEAD, ST_CHECK, ST_SEND, ST_GAP, ST_TRAIL, ST_HALT
  } state_t;

  localparam int DEPTH = 1 << AW;
  localparam int TMAX01 = (STARTUP_CYC > SS_LEAD_CYC) ? STARTUP_CYC : SS_LEAD_CYC;
  localparam int TMAX = (TMAX01 > SS_TRAIL_CYC) ? TMAX01 : SS_TRAIL_CYC;
  localparam int TW = $clog2(TMAX + 1);
  localparam int DVW = $clog2(CLK_DIV + 1);

  state_t          state;
  logic [TW-1:0]   timer;
  logic [DVW-1:0]  div_cnt;
  logic            halt_flag;

  logic [DW:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            empty;
  logic            push;
  logic            pop;
  logic [DW:0]     head;
  logic            head_marker;

  assign cmd_count   = count;
  assign cmd_full    = (count == (AW+1)'(DEPTH));
  assign empty       = (count == '0);
  assign push        = cmd_wr && !cmd_full;
  assign head        = mem[rd_ptr];
  assign head_marker = head[DW];
  assign dbg_state   = state;
  assign ena_2clk    = !spi_ss_n && (div_cnt == DVW'(CLK_DIV - 1));

  // Pops happen only where the FSM consumes the head: stray EOFs in IDLE, any word in CHECK.
  always_comb begin
    pop = 1'b0;
    case (state)
      ST_IDLE:  pop = !empty && head_marker && head[0];
      ST_CHECK: pop = !empty && (head_marker || !busy_spi);
      default:  pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      cmd_ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (cmd_wr && cmd_full) cmd_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (spi_ss_n || div_cnt == DVW'(CLK_DIV - 1)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_STARTUP;
      timer      <= '0;
      halt_flag  <= 1'b0;
      spi_ss_n   <= 1'b1;
      spi_send   <= 1'b0;
      data_spi   <= '0;
      spi_end_tx <= 1'b0;
    end else begin
      case (state)
        ST_STARTUP: begin
          if (timer == TW'(STARTUP_CYC - 1)) begin
            state <= ST_IDLE;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_IDLE: begin
          if (!empty && !pop) begin
            state    <= ST_LEAD;
            timer    <= '0;
            spi_ss_n <= 1'b0;
          end
        end
        ST_LEAD: begin
          if (timer == TW'(SS_LEAD_CYC - 1)) begin
            state <= ST_CHECK;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_CHECK: begin
          if (pop) begin
            timer <= '0;
            if (!head_marker) begin
              data_spi <= head[DW-1:0];
              spi_send <= 1'b1;
              state    <= ST_SEND;
            end else begin
              halt_flag <= !head[0];
              state     <= ST_TRAIL;
            end
          end
        end
        ST_SEND: begin
          spi_send <= 1'b0;
          state    <= ST_GAP;
          timer    <= '0;
        end
        // One idle cycle so the master's busy flag is visible before the next head check.
        ST_GAP: begin
          state <= ST_CHECK;
          timer <= '0;
        end
        ST_TRAIL: begin
          if (timer == TW'(SS_TRAIL_CYC - 1)) begin
            timer    <= '0;
            spi_ss_n <= 1'b1;
            if (halt_flag) begin
              state      <= ST_HALT;
              spi_end_tx <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_STARTUP;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_seq.sv
// Bench for spi_cmd_seq: scoreboard of sent bytes plus frame timing, busy back-pressure,
// stall, overflow, halt and mid-transfer reset scenarios.
module tb_spi_cmd_seq;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam logic [8:0] EOF_W  = 9'h101;
  localparam logic [8:0] HALT_W = 9'h100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_wr = 1'b0;
  logic [DW:0]   cmd_data = '0;
  logic          cmd_full;
  logic [AW:0]   cmd_count;
  logic          cmd_ovf;
  logic          busy_spi = 1'b0;
  logic          spi_ss_n;
  logic          spi_send;
  logic [DW-1:0] data_spi;
  logic          ena_2clk;
  logic          spi_end_tx;
  logic [2:0]    dbg_state;

  spi_cmd_seq dut (
    .clk(clk), .rst(rst), .cmd_wr(cmd_wr), .cmd_data(cmd_data), .cmd_full(cmd_full),
    .cmd_count(cmd_count), .cmd_ovf(cmd_ovf), .busy_spi(busy_spi), .spi_ss_n(spi_ss_n),
    .spi_send(spi_send), .data_spi(data_spi), .ena_2clk(ena_2clk), .spi_end_tx(spi_end_tx),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // frame monitor / scoreboard
  int rel_cyc, fall_cyc, rise_cyc, first_send_cyc, last_send_cyc, last_ena;
  int sends_in_frame, min_gap, rise_count;
  logic ss_prev = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      ss_prev = 1'b1;
      sends_in_frame = 0;
    end else begin
      if (ss_prev && !spi_ss_n) begin
        fall_cyc = cyc;
        sends_in_frame = 0;
        last_ena = -1;
        min_gap = 1000000;
      end
      if (!ss_prev && spi_ss_n) begin
        rise_cyc = cyc;
        rise_count++;
      end
      if (spi_send) begin
        check("send_ss_low", spi_ss_n, 1'b0);
        if (exp_q.size() == 0) check("unexpected_send", data_spi, 32'hFFFF_FFFF);
        else check("send_data", data_spi, exp_q.pop_front());
        if (sends_in_frame == 0) first_send_cyc = cyc;
        else if (cyc - last_send_cyc < min_gap) min_gap = cyc - last_send_cyc;
        last_send_cyc = cyc;
        sends_in_frame++;
      end
      if (ena_2clk) begin
        check("ena_ss_low", spi_ss_n, 1'b0);
        if (last_ena < 0) check("ena_first", cyc - fall_cyc, 11);
        else check("ena_period", cyc - last_ena, 12);
        last_ena = cyc;
      end
      ss_prev = spi_ss_n;
    end
  end

  // busy model: master busy for 40 cycles after each send when enabled
  bit busy_mode = 1'b0;
  int busy_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (busy_cnt > 0) busy_cnt--;
      if (busy_mode && spi_send) busy_cnt = 40;
      busy_spi = (busy_cnt > 0);
    end
  end

  // driver tasks
  task automatic reset_dut();
    rst = 1'b1;
    cmd_wr = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic wr(input logic [DW:0] w, input bit track);
    cmd_data = w;
    cmd_wr = 1'b1;
    if (track && !w[DW]) exp_q.push_back(w[DW-1:0]);
    @(negedge clk);
    cmd_wr = 1'b0;
  endtask

  task automatic wait_rise(input int budget);
    int start;
    start = rise_count;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rise_count != start) return;
    end
    check("timeout_ss_rise", 0, 1);
  endtask

  initial begin
    logic [DW:0] w;
    int w_cyc;
    bit seen;

    // reset values
    @(negedge clk);
    check("rst_ss_n", spi_ss_n, 1'b1);
    check("rst_send", spi_send, 1'b0);
    check("rst_data", data_spi, '0);
    check("rst_ena", ena_2clk, 1'b0);
    check("rst_end_tx", spi_end_tx, 1'b0);
    check("rst_ovf", cmd_ovf, 1'b0);
    check("rst_count", cmd_count, '0);
    check("rst_full", cmd_full, 1'b0);
    reset_dut();

    // 1: preloaded frame, startup/lead/trail timing
    wr(9'h003, 1'b1);
    wr(9'h00E, 1'b1);
    wr(EOF_W, 1'b1);
    wait_rise(3000);
    check("t1_startup", fall_cyc - rel_cyc, 1501);
    check("t1_lead", first_send_cyc - fall_cyc, 501);
    check("t1_trail", rise_cyc - last_send_cyc, 503);
    check("t1_sends", sends_in_frame, 2);
    check("t1_data_hold", data_spi, 8'h0E);
    wr(EOF_W, 1'b1);
    repeat (5) @(negedge clk);
    check("t1_eof_idle_pop", cmd_count, '0);
    check("t1_eof_idle_ss", spi_ss_n, 1'b1);

    // 2: busy back-pressure
    busy_mode = 1'b1;
    for (int i = 0; i < 3; i++) wr({1'b0, 8'($urandom_range(0, 255))}, 1'b1);
    wr(EOF_W, 1'b1);
    wait_rise(3000);
    check("t2_sends", sends_in_frame, 3);
    check("t2_gap_ge_41", min_gap >= 41, 1'b1);
    busy_mode = 1'b0;
    repeat (45) @(negedge clk);

    // 3: underrun stall until a late EOF
    wr(9'h011, 1'b1);
    repeat (520) @(negedge clk);
    repeat (200) @(negedge clk);
    check("t3_stall_ss", spi_ss_n, 1'b0);
    check("t3_stall_sends", sends_in_frame, 1);
    w_cyc = cyc;
    wr(EOF_W, 1'b1);
    wait_rise(3000);
    check("t3_close", rise_cyc - w_cyc, 502);

    // 4: overflow during startup
    reset_dut();
    for (int i = 0; i < 17; i++) begin
      w = {1'b0, 8'($urandom_range(0, 255))};
      wr(w, i < 16);
      if (i == 14) begin
        check("t4_count15", cmd_count, 15);
        check("t4_not_full", cmd_full, 1'b0);
      end
      if (i == 15) begin
        check("t4_full", cmd_full, 1'b1);
        check("t4_no_ovf_yet", cmd_ovf, 1'b0);
      end
    end
    check("t4_ovf", cmd_ovf, 1'b1);
    check("t4_count16", cmd_count, 16);
    check("t4_full_hold", cmd_full, 1'b1);
    repeat (2100) @(negedge clk);
    wr(EOF_W, 1'b1);
    wait_rise(3000);
    check("t4_sends", sends_in_frame, 16);
    check("t4_drained", cmd_count, '0);
    check("t4_ovf_sticky", cmd_ovf, 1'b1);

    // 5: halt marker
    wr(9'h0AA, 1'b1);
    wr(EOF_W, 1'b1);
    wr(HALT_W, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      seen = spi_end_tx;
    end
    check("t5_end_tx", spi_end_tx, 1'b1);
    check("t5_ss_off", spi_ss_n, 1'b1);
    wr(9'h055, 1'b0);
    wr(EOF_W, 1'b0);
    repeat (1200) @(negedge clk);
    check("t5_fifo_accepts", cmd_count, 2);
    check("t5_end_tx_hold", spi_end_tx, 1'b1);
    check("t5_ss_still_off", spi_ss_n, 1'b1);

    // 6: reset in the middle of a send
    reset_dut();
    for (int i = 0; i < 5; i++) wr({1'b0, 8'($urandom_range(0, 255))}, 1'b1);
    wr(EOF_W, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      seen = spi_send;
    end
    check("t6_send_seen", seen, 1'b1);
    rst = 1'b1;
    #1;
    check("t6_ss_n", spi_ss_n, 1'b1);
    check("t6_send", spi_send, 1'b0);
    check("t6_data", data_spi, '0);
    check("t6_count", cmd_count, '0);
    check("t6_ena", ena_2clk, 1'b0);
    check("t6_state", dbg_state, 3'd0);
    reset_dut();
    wr(9'h05A, 1'b1);
    wr(EOF_W, 1'b1);
    wait_rise(3000);
    check("t6_startup_again", fall_cyc - rel_cyc, 1501);
    check("t6_sends", sends_in_frame, 1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
